// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/response handshake
// and loads the IF/ID register with the fetched word and its PC+4.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        pcsrc,
    input  logic [31:0] pc_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    localparam logic S_REQ = 1'b0;
    localparam logic S_BUF = 1'b1;

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pending_q, pending_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    logic [31:0] branch_al;
    logic [31:0] pc_plus4;
    logic        bubble;

    // Low target bits are dropped by masking so every input bit is consumed.
    assign branch_al = pc_branch & ~32'h0000_0003;
    assign pc_plus4  = pc_q + 32'd4;

    assign imem_req  = (state_q == S_REQ) && !rst;
    assign imem_addr = pc_q;
    assign o_valid   = valid_q;
    assign o_instr   = instr_q;
    assign o_pc4     = pc4_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        pend_target_d = pend_target_q;
        buf_instr_d   = buf_instr_q;
        buf_pc4_d     = buf_pc4_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        pc4_d         = pc4_q;
        bubble        = 1'b0;

        if (state_q == S_BUF) begin
            if (flush) begin
                state_d = S_REQ;
                bubble  = 1'b1;
                if (pcsrc) begin
                    pc_d = branch_al;
                end
            end else if (pcsrc) begin
                state_d = S_REQ;
                pc_d    = branch_al;
                bubble  = !stall;
            end else if (!stall) begin
                state_d = S_REQ;
                valid_d = 1'b1;
                instr_d = buf_instr_q;
                pc4_d   = buf_pc4_q;
            end
        end else if (imem_ready) begin
            pending_d = 1'b0;
            // A redirect seen now or while waiting kills the returned word.
            if (pcsrc || pending_q) begin
                pc_d   = pcsrc ? branch_al : pend_target_q;
                bubble = flush || !stall;
            end else begin
                pc_d = pc_plus4;
                if (flush) begin
                    bubble = 1'b1;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    instr_d = imem_rdata;
                    pc4_d   = pc_plus4;
                end else begin
                    buf_instr_d = imem_rdata;
                    buf_pc4_d   = pc_plus4;
                    state_d     = S_BUF;
                end
            end
        end else begin
            if (pcsrc) begin
                pending_d     = 1'b1;
                pend_target_d = branch_al;
            end
            bubble = flush || !stall;
        end

        if (bubble) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pending_q     <= 1'b0;
            pend_target_q <= '0;
            buf_instr_q   <= '0;
            buf_pc4_q     <= '0;
            valid_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc4_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            pend_target_q <= pend_target_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc4_q     <= buf_pc4_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            pc4_q         <= pc4_d;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the Samba pipeline.
- Owns the architectural PC register and drives the instruction-memory request/response handshake.
- Loads the IF/ID pipeline register with the fetched instruction and PC+4.
- Accepts a redirect (pcsrc + pc_branch) from the PC-select path; supports stall and flush from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven on o_instr when the IF/ID slot is invalid

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  hazard unit: hold IF/ID register and PC
flush  input  1  hazard unit: invalidate IF/ID register and buffered fetch
pcsrc  input  1  redirect request; 1 = next PC is pc_branch
pc_branch  input  32  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= PC register)
imem_ready  input  1  memory completes the request this cycle
imem_rdata  input  32  instruction word, valid when imem_ready=1
o_pc4  output  32  IF/ID: PC+4 of the held instruction
o_instr  output  32  IF/ID: instruction word
o_valid  output  1  IF/ID: slot holds a real instruction

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high. All outputs are registered except imem_req, which decodes from state.
- Reset (rst=1 at an edge, overrides everything):
  - pc=RESET_PC, state=REQ, pending=0.
  - o_valid=0, o_instr=NOP_INSTR, o_pc4=0.
  - imem_req is 0 while rst is high and 1 in the first cycle after release.
- Reset asserted mid-request drops the request. The memory must tolerate an abandoned request.
- pc_branch[1:0] is ignored; the target is forced word-aligned. pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- FSM states:
  - REQ: imem_req=1, imem_addr=pc. Address is stable until imem_ready.
  - BUF: imem_req=0. A fetched instruction is held in buf_instr/buf_pc4 because stall was high.
- Priority per edge: rst > flush > redirect > normal.
- REQ, imem_ready=0:
  - pcsrc=1: pending<=1, pend_target<=pc_branch. A later pcsrc overwrites pend_target.
  - !stall: o_valid<=0 (bubble). stall: IF/ID holds.
- REQ, imem_ready=1:
  - If pending or pcsrc: discard rdata, pc<=target, pending<=0, stay REQ. pcsrc this cycle wins over pend_target. IF/ID gets a bubble if !stall.
  - Else if !stall: o_instr<=rdata, o_pc4<=pc+4, o_valid<=1, pc<=pc+4, stay REQ.
  - Else (stall): buf<=rdata and pc+4, pc<=pc+4, go to BUF. IF/ID holds.
- BUF:
  - pcsrc=1: discard buffer, pc<=pc_branch, go to REQ.
  - Else if !stall: IF/ID<=buffer (o_valid=1), go to REQ.
  - stall: remain in BUF.
- flush=1:
  - o_valid<=0, o_instr<=NOP_INSTR, regardless of stall.
  - In BUF: buffer discarded, go to REQ. pc is unchanged unless pcsrc is also 1.
  - In REQ with imem_ready=1: returned word is discarded; pc advances (pc+4, or the target if redirecting).
- Steady-state throughput with a 0-wait memory (imem_ready tied high) is one instruction per cycle. First o_valid=1 appears 1 cycle after rst deasserts.

Test Plan:
- Reset, zero-wait memory returning rdata=addr ^ 32'hA5A5_A5A5, no stall -> o_valid rises 1 cycle after rst; o_pc4 sequence 4,8,12..., with matching o_instr.
- 3-cycle memory latency; pcsrc=1, pc_branch=32'h100 pulsed during wait -> in-flight word discarded, next imem_addr=32'h100, no o_valid for the discarded word.
- stall held 4 cycles when imem_ready arrives at addr 8 -> state BUF, imem_req=0, IF/ID frozen. On release, o_instr=word@8 and o_pc4=12, then fetch resumes at 12.
- flush and stall together while in BUF -> o_valid=0 next cycle, buffered word lost, refetch of pc (next addr) without duplication.
- pc_branch=32'hFFFF_FFFE redirect -> imem_addr=32'hFFFF_FFFC, next o_pc4=0 (wrap).
- rst asserted while a request is outstanding -> next cycle imem_addr=RESET_PC, o_valid=0, pending cleared.
